mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multicycle memory-access sequencer sitting directly upstream of `memory_system`. It accepts instruction-fetch and load/store requests from the core, drives the memory system's address, write-data and write-enable inputs, and captures the combinational read result into an instruction register or a load-data register. It also enforces the ROM/RAM map: the ROM region is below `ROM_LIMIT`, stores there are blocked, and misaligned accesses are rejected.

## Interface
- `DATA_WIDTH`, 32, width of address and data paths.
- `ROM_LIMIT`, 32'h10000000, first RAM address; addresses below it are ROM (read-only).

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req_i` in 1: request an instruction fetch at `pc_i`.
- `pc_i` in DATA_WIDTH: fetch address.
- `data_req_i` in 1: request a data access.
- `data_we_i` in 1: 1 = store, 0 = load; sampled with `data_req_i`.
- `data_addr_i` in DATA_WIDTH: load/store address.
- `data_wdata_i` in DATA_WIDTH: store data.
- `mem_rdata_i` in DATA_WIDTH: read data from the memory system; combinational in the address.
- `mem_addr_o` out DATA_WIDTH: address to the memory system.
- `mem_wdata_o` out DATA_WIDTH: write data to the memory system.
- `mem_we_o` out 1: write enable to the memory system.
- `instr_o` out DATA_WIDTH: instruction register.
- `instr_valid_o` out 1: one-cycle pulse; `instr_o` has just been updated.
- `rdata_o` out DATA_WIDTH: load-data register.
- `data_done_o` out 1: one-cycle pulse; a load or store has completed.
- `err_o` out 1: one-cycle pulse; the access was rejected.
- `busy_o` out 1: high when not in IDLE; new requests are ignored while high.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE**
  - Accept a request when `fetch_req_i` or `data_req_i` is high.
  - `data_req_i` has priority when both are high. The fetch is not queued; the requester must hold it.
  - On accept, latch the kind (fetch/load/store), the address and the write data.
  - Go to ACCESS. Inputs may change after the accept edge.
- **Check at accept (rejected access):** a request is rejected if either condition holds:
  - the address has `addr[1:0] != 0`, or
  - it is a store with address < `ROM_LIMIT` (unsigned compare).
  
  A rejected access still goes to ACCESS, but `mem_we_o` stays 0 and neither register is written. In RESP, `err_o` pulses.
- **ACCESS (exactly one cycle)**
  - `mem_addr_o` = latched address; `mem_wdata_o` = latched data.
  - `mem_we_o` = 1 only for a valid store.
  - At the closing edge, a valid fetch writes `mem_rdata_i` into `instr_o` and a valid load writes it into `rdata_o`.
  - Go to RESP.
- **RESP (exactly one cycle)**
  - Fetch: `instr_valid_o` = 1.
  - Load/store: `data_done_o` = 1.
  - Rejected access: `err_o` = 1 and no done/valid pulse.
  - Go to IDLE.
- **Outside ACCESS:** `mem_we_o` = 0. `mem_addr_o` and `mem_wdata_o` hold the last latched values.
- `instr_o` and `rdata_o` hold their value until the next valid fetch or load.
- **Reset values (asserted asynchronously):**
  - State = IDLE.
  - `mem_addr_o`, `mem_wdata_o`, `instr_o` and `rdata_o` = 0.
  - `mem_we_o`, `instr_valid_o`, `data_done_o`, `err_o` and `busy_o` = 0.
- **Reset mid-operation:** the access is aborted immediately and `mem_we_o` drops without waiting for an edge. No pulse is emitted after reset releases.

## Timing
- Cycle 0: a request is high in IDLE (`busy_o` = 0) and is accepted at the end of the cycle.
- Cycle 1: ACCESS; memory is driven and `busy_o` = 1.
- Cycle 2: RESP; the result is visible in `instr_o` or `rdata_o` with its pulse, and `busy_o` = 1.
- Cycle 3: IDLE; the next request can be accepted at the end of this cycle.
- Throughput: one access per 3 cycles.
- Latency: request to result = 2 cycles.
- All outputs are registered except `mem_we_o`, which decodes directly from state plus the latched kind and valid flag.
- A request held high continuously is re-accepted every 3 cycles.

## Test plan
- **Fetch:** reset, then pulse `fetch_req_i` with `pc_i`=32'h0000_0004 and the ROM model returning 32'h2002_0005. Required: `mem_addr_o`=4 in cycle 1; `instr_o`=32'h2002_0005 and `instr_valid_o`=1 in cycle 2 only.
- **Store then load:** store 32'hDEAD_BEEF to 32'h1000_0008. Required: `mem_we_o`=1 for exactly cycle 1 and `data_done_o` in cycle 2. Then load from the same address. Required: `rdata_o`=32'hDEAD_BEEF in cycle 2.
- **Store into ROM:** store to 32'h0000_0010. Required: `mem_we_o` never rises, `err_o`=1 in cycle 2, `data_done_o`=0, and ROM contents unchanged.
- **Misaligned load:** load from 32'h1000_0002. Required: `err_o` pulse, and `rdata_o` keeps its previous value.
- **Simultaneous requests:** `fetch_req_i`=`data_req_i`=1 (load 32'h1000_0000) with fetch held high. Required: the load completes in cycle 2; the fetch is accepted in cycle 3 and `instr_valid_o` rises in cycle 5.
- **Reset mid-store:** deassert `rst_n` during ACCESS of a store. Required: `mem_we_o` falls to 0 in the same cycle, all outputs are 0, and after release `busy_o`=0 with no pulses.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Bundles the core-side request signals, the memory-system signals and the
// result/status outputs of mem_access_ctrl.
//
// Handshake contract:
//   fetch_req_i / data_req_i are level requests. A request is taken on the
//   rising edge where it is high while busy_o is low. data_req_i wins when
//   both are high, and the losing fetch is not queued. Request inputs may
//   change after the accepting edge. Results appear as one-cycle pulses:
//   instr_valid_o, data_done_o or err_o. While busy_o is high, requests are
//   ignored.
//
// Modports:
//   slave  - the controller (consumes requests and read data; drives memory,
//            results and debug state)
//   master - the core plus memory model that surrounds it
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // core side
  logic                  fetch_req_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic                  data_req_i;
  logic                  data_we_i;
  logic [DATA_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  // memory side
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  // results / status
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  data_done_o;
  logic                  err_o;
  logic                  busy_o;
  // debug: current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
  logic [1:0]            state_o;

  modport slave (
    input  fetch_req_i, pc_i, data_req_i, data_we_i, data_addr_i,
           data_wdata_i, mem_rdata_i,
    output mem_addr_o, mem_wdata_o, mem_we_o, instr_o, instr_valid_o,
           rdata_o, data_done_o, err_o, busy_o, state_o
  );

  modport master (
    output fetch_req_i, pc_i, data_req_i, data_we_i, data_addr_i,
           data_wdata_i, mem_rdata_i,
    input  mem_addr_o, mem_wdata_o, mem_we_o, instr_o, instr_valid_o,
           rdata_o, data_done_o, err_o, busy_o, state_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Three-state (IDLE -> ACCESS -> RESP) sequencer in front of the memory
// system. It accepts one fetch or load/store in IDLE, drives the memory for
// exactly one cycle in ACCESS, and reports in RESP. Addresses below ROM_LIMIT
// are read-only. Misaligned accesses and ROM stores are rejected: they walk
// the same three states, but they never write and they pulse err_o.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_access_ctrl_if.slave (requests, memory bus, results, state)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_LIMIT  = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  is_fetch_q, is_fetch_d;
  logic                  is_store_q, is_store_d;
  logic                  ok_q, ok_d;          // access passed the accept checks
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  data_done_q, data_done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  // request decode (only meaningful in IDLE)
  logic                  req_any;
  logic                  req_store;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  req_ok;

  always_comb begin
    req_any   = bus.fetch_req_i | bus.data_req_i;
    req_store = bus.data_req_i & bus.data_we_i;
    req_addr  = bus.data_req_i ? bus.data_addr_i : bus.pc_i;
    req_ok    = (req_addr[1:0] == 2'b00) && !(req_store && (req_addr < ROM_LIMIT));
  end

  always_comb begin
    state_d       = state_q;
    is_fetch_d    = is_fetch_q;
    is_store_d    = is_store_q;
    ok_d          = ok_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    instr_d       = instr_q;
    rdata_d       = rdata_q;
    instr_valid_d = 1'b0;
    data_done_d   = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d    = S_ACCESS;
          is_fetch_d = ~bus.data_req_i;
          is_store_d = req_store;
          ok_d       = req_ok;
          addr_d     = req_addr;
          // a fetch leaves the write-data bus at its last value
          if (bus.data_req_i) wdata_d = bus.data_wdata_i;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        // read data is combinational in mem_addr_o, so it is valid now
        if (ok_q && is_fetch_q)                 instr_d = bus.mem_rdata_i;
        if (ok_q && !is_fetch_q && !is_store_q) rdata_d = bus.mem_rdata_i;
        // pulses are registered so they land in the RESP cycle
        instr_valid_d = ok_q & is_fetch_q;
        data_done_d   = ok_q & ~is_fetch_q;
        err_d         = ~ok_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      is_fetch_q    <= 1'b0;
      is_store_q    <= 1'b0;
      ok_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      instr_q       <= '0;
      rdata_q       <= '0;
      instr_valid_q <= 1'b0;
      data_done_q   <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_fetch_q    <= is_fetch_d;
      is_store_q    <= is_store_d;
      ok_q          <= ok_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      instr_q       <= instr_d;
      rdata_q       <= rdata_d;
      instr_valid_q <= instr_valid_d;
      data_done_q   <= data_done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  // Decoded from state so that an asynchronous reset drops it at once.
  assign bus.mem_we_o      = (state_q == S_ACCESS) && is_store_q && ok_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_wdata_o   = wdata_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = instr_valid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.data_done_o   = data_done_q;
  assign bus.err_o         = err_q;
  assign bus.busy_o        = busy_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int          DW        = 32;
  localparam logic [31:0] ROM_LIMIT = 32'h1000_0000;
  localparam logic [31:0] ROM_KEY   = 32'h2002_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(DW), .ROM_LIMIT(ROM_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- memory system model ----------------
  // ROM word at address a reads as a ^ ROM_KEY (so 4 -> 32'h2002_0005).
  // RAM is a small word array. Any write into ROM space is counted.
  logic [31:0] ram [0:255];
  int          rom_wr_cnt;

  assign bus.mem_rdata_i = (bus.mem_addr_o >= ROM_LIMIT) ? ram[bus.mem_addr_o[9:2]]
                                                         : (bus.mem_addr_o ^ ROM_KEY);

  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      if (bus.mem_addr_o < ROM_LIMIT) rom_wr_cnt <= rom_wr_cnt + 1;
      else                            ram[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_ram [logic [31:0]];
  logic [31:0] exp_instr, exp_rdata;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a < ROM_LIMIT) return a ^ ROM_KEY;
    if (ref_ram.exists(a)) return ref_ram[a];
    return 32'h0;
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pulses();
    return {29'd0, bus.instr_valid_o, bus.data_done_o, bus.err_o};
  endfunction

  // ---------------- driver ----------------
  task automatic clear_reqs();
    bus.fetch_req_i  = 1'b0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store. Entered and left at a negedge in IDLE.
  task automatic access(input string tag, input int kind,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        rej;
    logic [31:0] exp_p;
    rej = (addr[1:0] != 2'b00) || (kind == 2 && addr < ROM_LIMIT);
    if (rej)            exp_p = 32'd1;
    else if (kind == 0) exp_p = 32'd4;
    else                exp_p = 32'd2;

    chk({tag, ".c0_busy"}, {31'd0, bus.busy_o}, 32'd0);
    if (kind == 0) begin
      bus.fetch_req_i = 1'b1;
      bus.pc_i        = addr;
    end else begin
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = (kind == 2);
      bus.data_addr_i  = addr;
      bus.data_wdata_i = wd;
    end
    @(posedge clk); #1;
    clear_reqs();
    bus.pc_i         = $urandom;
    bus.data_addr_i  = $urandom;
    bus.data_wdata_i = $urandom;

    @(negedge clk); // cycle 1: ACCESS
    chk({tag, ".c1_busy"}, {31'd0, bus.busy_o}, 32'd1);
    chk({tag, ".c1_addr"}, bus.mem_addr_o, addr);
    chk({tag, ".c1_we"}, {31'd0, bus.mem_we_o}, {31'd0, (kind == 2) && !rej});
    if (kind == 2 && !rej) chk({tag, ".c1_wdata"}, bus.mem_wdata_o, wd);
    chk({tag, ".c1_pulses"}, pulses(), 32'd0);

    if (!rej && kind == 0) exp_instr = ref_read(addr);
    if (!rej && kind == 1) exp_rdata = ref_read(addr);
    if (!rej && kind == 2) ref_ram[addr] = wd;

    @(negedge clk); // cycle 2: RESP
    chk({tag, ".c2_busy"}, {31'd0, bus.busy_o}, 32'd1);
    chk({tag, ".c2_pulses"}, pulses(), exp_p);
    chk({tag, ".c2_we"}, {31'd0, bus.mem_we_o}, 32'd0);
    chk({tag, ".c2_instr"}, bus.instr_o, exp_instr);
    chk({tag, ".c2_rdata"}, bus.rdata_o, exp_rdata);

    @(negedge clk); // cycle 3: IDLE again
    chk({tag, ".c3_busy"}, {31'd0, bus.busy_o}, 32'd0);
    chk({tag, ".c3_pulses"}, pulses(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    rom_wr_cnt       = 0;
    exp_instr        = 32'h0;
    exp_rdata        = 32'h0;
    rst_n            = 1'b0;
    clear_reqs();
    bus.pc_i         = 32'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;

    // reset values
    #12;
    chk("rst.addr", bus.mem_addr_o, 32'h0);
    chk("rst.wdata", bus.mem_wdata_o, 32'h0);
    chk("rst.instr", bus.instr_o, 32'h0);
    chk("rst.rdata", bus.rdata_o, 32'h0);
    chk("rst.flags", {27'd0, bus.mem_we_o, bus.instr_valid_o, bus.data_done_o,
                      bus.err_o, bus.busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed plan
    access("fetch", 0, 32'h0000_0004, 32'h0);
    chk("fetch.instr_const", bus.instr_o, 32'h2002_0005);
    access("store", 2, 32'h1000_0008, 32'hDEAD_BEEF);
    access("load", 1, 32'h1000_0008, 32'h0);
    chk("load.rdata_const", bus.rdata_o, 32'hDEAD_BEEF);
    access("rom_store", 2, 32'h0000_0010, 32'h1234_5678);
    access("rom_after", 1, 32'h0000_0010, 32'h0);
    access("misaligned", 1, 32'h1000_0002, 32'h0);
    access("mis_fetch", 0, 32'h1000_0006, 32'h0);

    // simultaneous requests: load wins, held fetch follows
    begin
      logic [31:0] pc_s;
      pc_s = 32'h0000_0040;
      chk("sim.c0_busy", {31'd0, bus.busy_o}, 32'd0);
      bus.fetch_req_i = 1'b1;
      bus.pc_i        = pc_s;
      bus.data_req_i  = 1'b1;
      bus.data_we_i   = 1'b0;
      bus.data_addr_i = 32'h1000_0000;
      @(posedge clk); #1;
      bus.data_req_i = 1'b0;
      exp_rdata = ref_read(32'h1000_0000);
      @(negedge clk);
      chk("sim.c1_addr", bus.mem_addr_o, 32'h1000_0000);
      @(negedge clk);
      chk("sim.c2_pulses", pulses(), 32'd2);
      chk("sim.c2_rdata", bus.rdata_o, exp_rdata);
      @(negedge clk);
      chk("sim.c3_busy", {31'd0, bus.busy_o}, 32'd0);
      @(posedge clk); #1;
      bus.fetch_req_i = 1'b0;
      exp_instr = ref_read(pc_s);
      @(negedge clk);
      chk("sim.c4_addr", bus.mem_addr_o, pc_s);
      chk("sim.c4_pulses", pulses(), 32'd0);
      @(negedge clk);
      chk("sim.c5_pulses", pulses(), 32'd4);
      chk("sim.c5_instr", bus.instr_o, exp_instr);
      @(negedge clk);
    end

    // reset in the middle of a store
    chk("rstmid.c0_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_addr_i  = 32'h1000_0010;
    bus.data_wdata_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    chk("rstmid.c1_we", {31'd0, bus.mem_we_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.we_drop", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rstmid.addr", bus.mem_addr_o, 32'h0);
    chk("rstmid.wdata", bus.mem_wdata_o, 32'h0);
    chk("rstmid.instr", bus.instr_o, 32'h0);
    chk("rstmid.rdata", bus.rdata_o, 32'h0);
    chk("rstmid.flags", {28'd0, bus.instr_valid_o, bus.data_done_o, bus.err_o,
                         bus.busy_o}, 32'h0);
    exp_instr = 32'h0;
    exp_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid.post%0d", i),
          {28'd0, bus.instr_valid_o, bus.data_done_o, bus.err_o, bus.busy_o}, 32'h0);
    end
    access("rstmid.readback", 1, 32'h1000_0010, 32'h0);

    // randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      int          kind;
      int          region;
      logic [31:0] a;
      kind   = $urandom_range(0, 2);
      region = $urandom_range(0, 9);
      if (region < 6)      a = ROM_LIMIT + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      else if (region < 8) a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else                 a = ROM_LIMIT + {26'd0, 4'($urandom_range(0, 15)),
                                            2'($urandom_range(1, 3))};
      access($sformatf("rnd%0d", n), kind, a, $urandom);
    end

    chk("rom_untouched", rom_wr_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
